// File: rtl/control_unit_demo.sv
// control_unit_demo: RV32I main decoder on board switches, control fields shown on an 8-digit 7-seg display.
// Define SW_SYNC_EN to add a 2-flop synchronizer on the switches.
module control_unit_demo #(
    parameter int SCAN_DIV = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] sw_i,
    output logic [7:0]  hex_o,
    output logic        dp_o,
    output logic [7:0]  an_o
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [10:0] sw_q;
    logic        unused_sw;
    assign unused_sw = ^sw_i[15:11];

`ifdef SW_SYNC_EN
    logic [10:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sw_q    <= '0;
        end else begin
            sync1_q <= sw_i[10:0];
            sync2_q <= sync1_q;
            sw_q    <= sync2_q;
        end
`else
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) sw_q <= '0;
        else       sw_q <= sw_i[10:0];
`endif

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;
    assign opcode = sw_q[6:0];
    assign f3     = sw_q[9:7];
    assign f7b5   = sw_q[10];

    logic [4:0] alu_op;
    logic [1:0] src_a_sel;
    logic [2:0] src_b_sel, mem_size;
    logic       mem_req, mem_we, gpr_we, wb_src, branch, jal, jalr, illegal;

    always_comb begin
        alu_op    = '0;
        src_a_sel = '0;
        src_b_sel = '0;
        mem_size  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        gpr_we    = 1'b0;
        wb_src    = 1'b0;
        branch    = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            7'b0110011: begin
                alu_op  = {1'b0, f7b5, f3};
                gpr_we  = 1'b1;
                illegal = f7b5 && f3 != 3'b000 && f3 != 3'b101;
            end
            7'b0010011: begin
                src_b_sel = 3'd1;
                gpr_we    = 1'b1;
                alu_op    = {1'b0, f7b5 && f3 == 3'b101, f3};
                illegal   = f7b5 && f3 == 3'b001;
            end
            7'b0000011: begin
                src_b_sel = 3'd1;
                mem_req   = 1'b1;
                gpr_we    = 1'b1;
                wb_src    = 1'b1;
                mem_size  = f3;
                illegal   = f3 == 3'b011 || f3[2:1] == 2'b11;
            end
            7'b0100011: begin
                src_b_sel = 3'd3;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_size  = f3;
                illegal   = f3 > 3'b010;
            end
            7'b1100011: begin
                alu_op  = {2'b11, f3};
                branch  = 1'b1;
                illegal = f3[2:1] == 2'b01;
            end
            7'b1101111: begin
                src_a_sel = 2'd1;
                src_b_sel = 3'd4;
                gpr_we    = 1'b1;
                jal       = 1'b1;
            end
            7'b1100111: begin
                src_a_sel = 2'd1;
                src_b_sel = 3'd4;
                gpr_we    = 1'b1;
                jalr      = 1'b1;
                illegal   = f3 != 3'b000;
            end
            7'b0110111: begin
                src_a_sel = 2'd2;
                src_b_sel = 3'd2;
                gpr_we    = 1'b1;
            end
            7'b0010111: begin
                src_a_sel = 2'd1;
                src_b_sel = 3'd2;
                gpr_we    = 1'b1;
            end
            7'b0001111: ;
            default: illegal = 1'b1;
        endcase
        // An illegal instruction must not cause any architectural side effect
        if (illegal) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            gpr_we  = 1'b0;
            branch  = 1'b0;
            jal     = 1'b0;
            jalr    = 1'b0;
        end
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q;
    logic [31:0]   digits;
    logic [3:0]    dig;

    assign digits = {3'b000, illegal, branch, jal, jalr, 1'b0, 1'b0, mem_size,
                     mem_req, mem_we, gpr_we, wb_src, 1'b0, src_b_sel,
                     2'b00, src_a_sel, 3'b000, alu_op[4], alu_op[3:0]};
    assign dig    = digits[idx_q*4 +: 4];
    assign cnt_d  = cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
    assign idx_d  = cnt_q == CNT_MAX ? idx_q + 3'd1 : idx_q;

    always_comb begin
        case (dig)
            4'h0: seg_d = 7'h40;
            4'h1: seg_d = 7'h79;
            4'h2: seg_d = 7'h24;
            4'h3: seg_d = 7'h30;
            4'h4: seg_d = 7'h19;
            4'h5: seg_d = 7'h12;
            4'h6: seg_d = 7'h02;
            4'h7: seg_d = 7'h78;
            4'h8: seg_d = 7'h00;
            4'h9: seg_d = 7'h10;
            4'hA: seg_d = 7'h08;
            4'hB: seg_d = 7'h03;
            4'hC: seg_d = 7'h46;
            4'hD: seg_d = 7'h21;
            4'hE: seg_d = 7'h06;
            default: seg_d = 7'h0E;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= ~(8'd1 << idx_q);
            seg_q <= seg_d;
            dp_q  <= ~illegal;
        end

    assign an_o  = an_q;
    assign dp_o  = dp_q;
    assign hex_o = {dp_q, seg_q};
endmodule

// File: tb/tb_control_unit_demo.sv
// tb_control_unit_demo: directed decode and scan checks for control_unit_demo.
module tb_control_unit_demo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw  = 16'h018E;
    logic [7:0]  hex_o, an_o;
    logic        dp_o;
    int          total = 0;
    int          bad   = 0;

    control_unit_demo #(.SCAN_DIV(16)) dut (
        .clk_i(clk), .rst_i(rst), .sw_i(sw),
        .hex_o(hex_o), .dp_o(dp_o), .an_o(an_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_sw(input logic [15:0] v);
        sw = v;
        repeat (6) @(negedge clk);
    endtask

    // Wait for digit d to be driven, then check its segments and decimal point
    task automatic dig(input string tag, input int d, input logic [6:0] seg, input logic dp);
        logic [7:0] pat;
        int n;
        pat = ~(8'd1 << d);
        n = 0;
        @(negedge clk);
        while (an_o !== pat && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_an"}, an_o, pat);
        chk({tag, "_seg"}, {1'b0, hex_o[6:0]}, {1'b0, seg});
        chk({tag, "_dp"}, {6'b0, hex_o[7], dp_o}, {6'b0, dp, dp});
    endtask

    initial begin
        #20;
        chk("rst_an", an_o, 8'hFF);
        chk("rst_hex", hex_o, 8'hFF);
        chk("rst_dp", {7'b0, dp_o}, 8'h01);
        #280;
        @(negedge clk);
        rst = 1'b0;
        set_sw(16'h018E);
        dig("ill_d7", 7, 7'h79, 1'b0);
        dig("ill_d0", 0, 7'h40, 1'b0);
        dig("ill_d4", 4, 7'h40, 1'b0);
        dig("ill_d5", 5, 7'h40, 1'b0);
        set_sw(16'h0033);
        dig("add_d0", 0, 7'h40, 1'b1);
        dig("add_d4", 4, 7'h24, 1'b1);
        dig("add_d7", 7, 7'h40, 1'b1);
        set_sw(16'h0433);
        dig("sub_d0", 0, 7'h00, 1'b1);
        dig("sub_d1", 1, 7'h40, 1'b1);
        set_sw(16'h0533);
        dig("opill_d4", 4, 7'h40, 1'b0);
        dig("opill_d7", 7, 7'h79, 1'b0);
        dig("opill_d0", 0, 7'h08, 1'b0);
        set_sw(16'h0103);
        dig("lw_d3", 3, 7'h79, 1'b1);
        dig("lw_d4", 4, 7'h03, 1'b1);
        dig("lw_d5", 5, 7'h24, 1'b1);
        set_sw(16'h0063);
        dig("beq_d0", 0, 7'h00, 1'b1);
        dig("beq_d1", 1, 7'h79, 1'b1);
        dig("beq_d6", 6, 7'h00, 1'b1);
        set_sw(16'h006F);
        dig("jal_d2", 2, 7'h79, 1'b1);
        dig("jal_d3", 3, 7'h19, 1'b1);
        dig("jal_d6", 6, 7'h19, 1'b1);
        set_sw(16'h0037);
        dig("lui_d2", 2, 7'h24, 1'b1);
        dig("lui_d3", 3, 7'h24, 1'b1);
        set_sw(16'h0031);
        dig("q0_d7", 7, 7'h79, 1'b0);
        set_sw(16'h00E7);
        dig("jalr_bad_d6", 6, 7'h40, 1'b0);

        // Align to the first cycle of digit 0, then walk the full scan once plus one digit
        begin
            int n;
            logic [7:0] prev;
            n = 0;
            @(negedge clk);
            prev = an_o;
            @(negedge clk);
            while (!(prev !== 8'hFE && an_o === 8'hFE) && n < 400) begin
                prev = an_o;
                @(negedge clk);
                n++;
            end
            chk("scan_align", an_o, 8'hFE);
            for (int d = 0; d < 9; d++) begin
                for (int c = 0; c < 16; c++) begin
                    if (d != 0 || c != 0) @(negedge clk);
                    chk($sformatf("scan_d%0d_c%0d", d, c), an_o, ~(8'd1 << (d % 8)));
                end
            end
        end

        repeat (37) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", an_o, 8'hFF);
        chk("arst_hex", hex_o, 8'hFF);
        chk("arst_dp", {7'b0, dp_o}, 8'h01);
        #97;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1 || c == 16) chk($sformatf("resume_c%0d", c), an_o, 8'hFE);
            if (c == 17) chk("resume_next", an_o, 8'hFD);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
